// File: rtl/interboard_pkg.sv
// rtl/interboard_pkg.sv - shared types, defaults and message field layout for interboard_link
package interboard_pkg;

  localparam int DEFAULT_DATA_W = 6;
  localparam int DEFAULT_MSG_W  = 24;

  // Number of DATA_W beats needed to carry a MSG_W payload
  function automatic int beats_f(input int msg_w, input int data_w);
    return (msg_w + data_w - 1) / data_w;
  endfunction

  localparam int DEFAULT_BEATS = beats_f(DEFAULT_MSG_W, DEFAULT_DATA_W);

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_SEND     = 2'd1,
    TX_WAIT_ACK = 2'd2,
    TX_WAIT_REL = 2'd3
  } tx_state_t;

  // Game message layout inside tx_msg / rx_msg (LSB offsets and widths)
  localparam int MSG_TYPE_LSB = 0;
  localparam int MSG_TYPE_W   = 4;
  localparam int CARD_LSB     = 4;
  localparam int CARD_W       = 6;
  localparam int BLOCK_X_LSB  = 10;
  localparam int BLOCK_X_W    = 4;
  localparam int BLOCK_Y_LSB  = 14;
  localparam int BLOCK_Y_W    = 4;
  localparam int SEL_LEN_LSB  = 18;
  localparam int SEL_LEN_W    = 4;
  localparam int MOVE_DIR_LSB = 22;
  localparam int MOVE_DIR_W   = 2;

  // Packs the game fields into a default-width message
  function automatic logic [DEFAULT_MSG_W-1:0] pack_msg(
    input logic [MSG_TYPE_W-1:0] msg_type,
    input logic [CARD_W-1:0]     card,
    input logic [BLOCK_X_W-1:0]  block_x,
    input logic [BLOCK_Y_W-1:0]  block_y,
    input logic [SEL_LEN_W-1:0]  sel_len,
    input logic [MOVE_DIR_W-1:0] move_dir
  );
    return {move_dir, sel_len, block_y, block_x, card, msg_type};
  endfunction

endpackage

// File: rtl/interboard_link_fifo.sv
// rtl/interboard_link_fifo.sv - show-ahead synchronous FIFO with occupancy output
module interboard_link_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/interboard_link.sv
// rtl/interboard_link.sv - full-duplex Request/Ack message link; parity beat when INTERBOARD_LINK_PARITY_EN is defined
module interboard_link
  import interboard_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MSG_W       = DEFAULT_MSG_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [MSG_W-1:0]              tx_msg,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          rx_valid,
  output logic [MSG_W-1:0]              rx_msg,
  input  logic                          Request_in,
  input  logic                          Ack_in,
  input  logic [DATA_W-1:0]             inter_data_in,
  output logic                          Request_out,
  output logic                          Ack_out,
  output logic [DATA_W-1:0]             inter_data_out,
  output logic                          link_busy,
  output logic                          tx_timeout_err,
  input  logic                          clr_err
`ifdef INTERBOARD_LINK_PARITY_EN
  ,
  output logic                          rx_parity_err
`endif
);

  localparam int BEATS = beats_f(MSG_W, DATA_W);
  localparam int PAD_W = BEATS * DATA_W;
`ifdef INTERBOARD_LINK_PARITY_EN
  localparam int FRAME_BEATS = BEATS + 1;
`else
  localparam int FRAME_BEATS = BEATS;
`endif
  localparam int BW = $clog2(FRAME_BEATS + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
  logic                   w_req_s;
  logic                   w_ack_s;
  logic [DATA_W-1:0]      w_data_s;

  assign w_req_s  = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Data shares the request's depth so a captured beat lines up with its request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_req_sync[0]  <= Request_in;
      r_ack_sync[0]  <= Ack_in;
      r_data_sync[0] <= inter_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_req_sync[i]  <= r_req_sync[i-1];
        r_ack_sync[i]  <= r_ack_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  // ---------------- TX message FIFO ----------------
  logic              r_out_en;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [MSG_W-1:0]  w_fifo_data;

  assign tx_ready = r_out_en && !w_fifo_full;
  assign w_push   = tx_valid && tx_ready;

  // Holds tx_ready low while in reset and until the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_out_en <= 1'b0;
    else      r_out_en <= 1'b1;
  end

  interboard_link_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (tx_msg),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (tx_level)
  );

  // ---------------- TX FSM ----------------
  tx_state_t         r_tx_state;
  logic [BW-1:0]     r_tx_beat;
  logic [PAD_W-1:0]  r_tx_shift;
  logic [DATA_W-1:0] r_tx_par;
  logic [CW-1:0]     r_tx_cnt;
  logic              r_req_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_tx_err;
  logic [PAD_W-1:0]  w_head_pad;
  logic [PAD_W-1:0]  w_shift_next;
  logic [DATA_W-1:0] w_next_data;
  logic              w_tx_last;
  logic              w_tx_to;

  assign w_head_pad   = PAD_W'(w_fifo_data);
  assign w_shift_next = r_tx_shift >> DATA_W;
  assign w_tx_last    = (r_tx_beat == BW'(FRAME_BEATS - 1));
  assign w_tx_to      = (((r_tx_state == TX_WAIT_ACK) && !w_ack_s) ||
                         ((r_tx_state == TX_WAIT_REL) &&  w_ack_s)) &&
                        (r_tx_cnt == CW'(TIMEOUT - 1));
  assign w_pop        = ((r_tx_state == TX_WAIT_REL) && !w_ack_s && w_tx_last) || w_tx_to;
  assign link_busy    = (r_tx_state != TX_IDLE) || !w_fifo_empty;

  // Next beat to drive: the following payload slice, or the running XOR as the parity beat
  always_comb begin
    w_next_data = w_shift_next[DATA_W-1:0];
`ifdef INTERBOARD_LINK_PARITY_EN
    if (r_tx_beat == BW'(BEATS - 1)) w_next_data = r_tx_par;
`endif
  end

  // Beat sequencer: load head, raise request, wait ack high, wait ack low, repeat per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_beat  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= '0;
      r_tx_cnt   <= '0;
      r_req_out  <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_cnt <= '0;
          if (!w_fifo_empty) begin
            r_tx_shift <= w_head_pad;
            r_data_out <= w_head_pad[DATA_W-1:0];
            r_tx_par   <= w_head_pad[DATA_W-1:0];
            r_tx_beat  <= '0;
            r_tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          r_req_out  <= 1'b1;
          r_tx_cnt   <= '0;
          r_tx_state <= TX_WAIT_ACK;
        end
        TX_WAIT_ACK: begin
          if (w_ack_s) begin
            r_req_out  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_WAIT_REL;
          end else if (w_tx_to) begin
            r_req_out  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_WAIT_REL: begin
          if (!w_ack_s) begin
            r_tx_cnt <= '0;
            if (w_tx_last) begin
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_beat  <= r_tx_beat + 1'b1;
              r_tx_shift <= w_shift_next;
              r_data_out <= w_next_data;
              r_tx_par   <= r_tx_par ^ w_next_data;
              r_tx_state <= TX_SEND;
            end
          end else if (w_tx_to) begin
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_tx_err <= 1'b0;
    else if (w_tx_to)  r_tx_err <= 1'b1;
    else if (clr_err)  r_tx_err <= 1'b0;
  end

  assign Request_out    = r_req_out;
  assign inter_data_out = r_data_out;
  assign tx_timeout_err = r_tx_err;

  // ---------------- RX path ----------------
  logic              r_ack_out;
  logic [BW-1:0]     r_rx_beat;
  logic [PAD_W-1:0]  r_rx_buf;
  logic [MSG_W-1:0]  r_rx_msg;
  logic              r_rx_valid;
  logic              r_req_prev;
  logic [CW-1:0]     r_rx_cnt;
  logic              w_rx_cap;
  logic              w_rx_rel;
  logic              w_rx_last;
  logic              w_rx_hit;
  logic              w_rx_good;

  assign w_rx_cap  = w_req_s && !r_ack_out;
  assign w_rx_rel  = !w_req_s && r_ack_out;
  assign w_rx_last = (r_rx_beat == BW'(FRAME_BEATS - 1));
  assign w_rx_hit  = (r_rx_cnt >= CW'(TIMEOUT - 1));

  // Inactivity counter for a partial frame; restarts on every request rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_prev <= 1'b0;
      r_rx_cnt   <= '0;
    end else begin
      r_req_prev <= w_req_s;
      if ((w_req_s && !r_req_prev) || (r_rx_beat == '0)) r_rx_cnt <= '0;
      else if (!w_rx_hit)                                r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  // Capture on request, release on request drop, deliver after the last beat, drop stale partials
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_out  <= 1'b0;
      r_rx_beat  <= '0;
      r_rx_buf   <= '0;
      r_rx_msg   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_rx_cap) begin
        r_ack_out <= 1'b1;
        for (int b = 0; b < BEATS; b++)
          if (r_rx_beat == BW'(b)) r_rx_buf[b*DATA_W +: DATA_W] <= w_data_s;
      end else if (w_rx_rel) begin
        r_ack_out <= 1'b0;
        if (w_rx_last) begin
          r_rx_beat <= '0;
          if (w_rx_good) begin
            r_rx_msg   <= r_rx_buf[MSG_W-1:0];
            r_rx_valid <= 1'b1;
          end
        end else begin
          r_rx_beat <= r_rx_beat + 1'b1;
        end
      end else if ((r_rx_beat != '0) && w_rx_hit) begin
        r_rx_beat <= '0;
      end
    end
  end

`ifdef INTERBOARD_LINK_PARITY_EN
  logic [DATA_W-1:0] r_rx_xor;
  logic              r_rx_par_ok;
  logic              r_rx_par_err;

  assign w_rx_good     = r_rx_par_ok;
  assign rx_parity_err = r_rx_par_err;

  // Running XOR of payload beats, compared against the trailing parity beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_xor     <= '0;
      r_rx_par_ok  <= 1'b0;
      r_rx_par_err <= 1'b0;
    end else begin
      if (w_rx_cap) begin
        if (r_rx_beat == BW'(BEATS)) r_rx_par_ok <= (r_rx_xor == w_data_s);
        else if (r_rx_beat == '0)    r_rx_xor    <= w_data_s;
        else                         r_rx_xor    <= r_rx_xor ^ w_data_s;
      end
      if (w_rx_rel && w_rx_last && !r_rx_par_ok) r_rx_par_err <= 1'b1;
      else if (clr_err)                          r_rx_par_err <= 1'b0;
    end
  end
`else
  assign w_rx_good = 1'b1;
`endif

  assign Ack_out  = r_ack_out;
  assign rx_msg   = r_rx_msg;
  assign rx_valid = r_rx_valid;

endmodule
